// File: rtl/res_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Turns the calculator's registered result into sign + packed BCD digits.
module res_bcd_conv #(
  parameter int width  = 8,
  parameter int DIGITS = 5
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [2*width-1:0]    bin_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  neg_o,
  output logic                  busy_o,
  output logic                  valid_o
);

  localparam int W  = 2 * width;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                start_q;
  logic                req;
  logic                accept;
  logic                last;
  logic                neg_in;
  logic                neg_f;
  logic [W-1:0]        mag_in;
  logic [W-1:0]        mag;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] scr;
  logic [4*DIGITS-1:0] scr_adj;
  logic [4*DIGITS-1:0] scr_nx;

  assign req    = start_i & ~start_q;
  assign accept = req & (state != SHIFT);
  assign last   = (state == SHIFT) && (cnt == CW'(1));
  assign neg_in = signed_i & bin_i[W-1];

  // Magnitude of -2**(W-1) is 2**(W-1), which still fits W unsigned bits.
  assign mag_in = neg_in ? (~bin_i + W'(1)) : bin_i;

  always_comb begin
    scr_adj = scr;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr[4*i +: 4] >= 4'd5)
        scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
  end

  assign scr_nx = {scr_adj[4*DIGITS-2:0], mag[W-1]};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (req)  state_nx = SHIFT;
      SHIFT:      if (last) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state == SHIFT);
    valid_o = (state == DONE);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      start_q <= 1'b0;
      mag     <= '0;
      neg_f   <= 1'b0;
      scr     <= '0;
      cnt     <= '0;
      bcd_o   <= '0;
      neg_o   <= 1'b0;
    end else begin
      start_q <= start_i;
      if (accept) begin
        mag   <= mag_in;
        neg_f <= neg_in;
        scr   <= '0;
        cnt   <= CW'(W);
      end else if (state == SHIFT) begin
        scr <= scr_nx;
        mag <= {mag[W-2:0], 1'b0};
        cnt <= cnt - CW'(1);
        if (last) begin
          bcd_o <= scr_nx;
          neg_o <= neg_f;
        end
      end
    end
  end

endmodule

// File: tb/tb_res_bcd_conv.sv
// Bench for res_bcd_conv: directed and random conversions
// against a decimal reference model.
module tb_res_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic        neg;
  logic        busy;
  logic        valid;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [19:0] last_exp = '0;
  logic        last_neg = 1'b0;

  res_bcd_conv #(.width(8), .DIGITS(5)) dut (
    .clock_i  (clk),
    .reset_i  (rst),
    .start_i  (start),
    .signed_i (sgn),
    .bin_i    (bin),
    .bcd_o    (bcd),
    .neg_o    (neg),
    .busy_o   (busy),
    .valid_o  (valid)
  );

  always #5 clk = ~clk;

  function automatic logic is_neg(input logic [15:0] b, input logic s);
    return s && (int'(b) >= 32768);
  endfunction

  function automatic logic [19:0] ref_bcd(input logic [15:0] b,
                                          input logic s);
    int unsigned m;
    logic [19:0] r;
    m = int'(b);
    if (is_neg(b, s)) m = 65536 - m;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [15:0] b, input logic s, input string tag);
    int n;
    @(negedge clk);
    bin   = b;
    sgn   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_busy_at_accept"}, 32'(busy), 32'd1);
    check({tag, "_held_bcd"}, 32'(bcd), 32'(last_exp));
    n = 0;
    while (!valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd16);
    check({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(b, s)));
    check({tag, "_neg"}, 32'(neg), 32'(is_neg(b, s)));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    last_exp = ref_bcd(b, s);
    last_neg = is_neg(b, s);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int          rises;
    int          fall;
    logic        prev;
    logic [15:0] b0;
    logic        s0;

    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(16'd10, 1'b0, "t1_10");
    check("t1_const", 32'(bcd), 32'h00010);
    run(16'hFFFC, 1'b1, "t2_m4");
    check("t2_const", 32'({neg, bcd}), 32'({1'b1, 20'h00004}));
    run(16'hFFFC, 1'b0, "t2_u");
    check("t2u_const", 32'(bcd), 32'h65532);
    run(16'h8000, 1'b1, "t3_min");
    check("t3_const", 32'({neg, bcd}), 32'({1'b1, 20'h32768}));
    run(16'hFFFF, 1'b0, "t3_max");
    check("t3m_const", 32'(bcd), 32'h65535);
    run(16'h0000, 1'b1, "zero_s");
    run(16'h0000, 1'b0, "zero_u");

    // level held high for 40 cycles
    @(negedge clk);
    b0 = 16'($urandom);
    bin = b0;
    sgn = 1'b0;
    start = 1'b1;
    rises = 0;
    prev = busy;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && !prev) rises++;
      prev = busy;
    end
    check("t4_one_conv", 32'(rises), 32'd1);
    check("t4_valid", 32'(valid), 32'd1);
    check("t4_bcd", 32'(bcd), 32'(ref_bcd(b0, 1'b0)));
    last_exp = ref_bcd(b0, 1'b0);
    start = 1'b0;
    @(negedge clk);

    // toggling start during SHIFT is ignored
    b0 = 16'd4321;
    bin = b0;
    sgn = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    fall = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (e == 3) start = 1'b0;
      if (e == 5) begin
        start = 1'b1;
        bin = 16'd9;
      end
      if (e == 7) start = 1'b0;
      @(posedge clk);
      #1;
      if (!busy && fall == 0) fall = e;
    end
    check("t4_busy_fall", 32'(fall), 32'd16);
    check("t4_toggle_bcd", 32'(bcd), 32'(ref_bcd(b0, 1'b1)));
    last_exp = ref_bcd(b0, 1'b1);

    // reset mid-SHIFT
    @(negedge clk);
    bin = 16'd999;
    sgn = 1'b0;
    start = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_bcd", 32'(bcd), 32'd0);
    check("t5_neg", 32'(neg), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(valid), 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_exp = '0;
    last_neg = 1'b0;
    run(16'd21, 1'b0, "t5_21");
    check("t5_const", 32'(bcd), 32'h00021);

    run(16'd255, 1'b0, "t6_255");
    run(16'd2, 1'b0, "t6_2");
    check("t6_const", 32'(bcd), 32'h00002);

    // start already high when reset releases
    @(negedge clk);
    rst = 1'b1;
    b0 = 16'($urandom);
    s0 = 1'($urandom);
    bin = b0;
    sgn = s0;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rises = 0;
    prev = busy;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy && !prev) rises++;
      prev = busy;
    end
    check("rel_one_conv", 32'(rises), 32'd1);
    check("rel_bcd", 32'({neg, bcd}), 32'({is_neg(b0, s0), ref_bcd(b0, s0)}));
    last_exp = ref_bcd(b0, s0);
    start = 1'b0;

    for (int k = 0; k < 24; k++) begin
      b0 = 16'($urandom);
      s0 = 1'($urandom);
      run(b0, s0, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
